// File: rtl/dds_spi_pkg.sv
// dds_spi_pkg: frame width, opcode set and FSM state encoding shared by the DDS SPI master.
package dds_spi_pkg;

   localparam int FRAME_BITS = 32;

   typedef enum logic [7:0] {
      OP_WRITE = 8'h01,
      OP_READ  = 8'h02,
      OP_CTRL  = 8'h03
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4,
      ST_TRIG  = 3'd5
   } state_t;

endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: one-cycle tick every CLK_DIV cycles while enabled; the count
// is held at zero while disabled, so each enable starts a fresh full period.
module spi_half_tick
   import dds_spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == CW'(CLK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!en || tick) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/dds_spi_master.sv
// dds_spi_master: SPI mode-0 initiator for the burst DDS CPLD plus its TRIG pulse.
// Define SPI_READBACK_EN to capture the last MISO byte of OP_READ frames into rd_data.
module dds_spi_master
   import dds_spi_pkg::*;
#(
   parameter int CLK_DIV     = 4,
   parameter int TRIG_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_op,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_data,
   input  logic        trig_req,
   output logic        busy,
   output logic        done,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        sck,
   output logic        mosi,
   input  logic        miso,
   output logic        spi_ce,
   output logic        trig
);
   localparam int TW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;

   state_t                state_q, state_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [5:0]            half_q, half_d;
   logic [TW-1:0]         tcnt_q, tcnt_d;
   logic                  trig_pend_q, trig_pend_d;
   logic                  done_q, done_d;
   logic                  tick, frame_act, ce_act, accept, go_trig;

   assign frame_act = state_q inside {ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP};
   assign ce_act    = state_q inside {ST_SETUP, ST_SHIFT, ST_HOLD};

   spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (frame_act),
      .tick (tick)
   );

   assign cmd_ready = (state_q == ST_IDLE) && !trig_pend_q;
   assign accept    = cmd_valid && cmd_ready;
   // A frame offered in the same IDLE cycle wins; the request then waits as pending.
   assign go_trig   = (state_q == ST_IDLE) && (trig_pend_q || trig_req) && !accept;

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      half_d      = half_q;
      tcnt_d      = tcnt_q;
      done_d      = 1'b0;
      trig_pend_d = (trig_pend_q || trig_req) && !go_trig;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SETUP;
               shreg_d = {cmd_op, cmd_addr, cmd_data};
               half_d  = '0;
            end else if (go_trig) begin
               state_d = ST_TRIG;
               tcnt_d  = '0;
            end
         end
         ST_SETUP: if (tick) state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (tick) begin
               half_d = half_q + 6'd1;
               // End of a high phase is the falling SCK edge: present the next bit.
               if (!half_q[0]) shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
               if (half_q == 6'd63) state_d = ST_HOLD;
            end
         end
         ST_HOLD: if (tick) state_d = ST_GAP;
         ST_GAP: begin
            if (tick) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         ST_TRIG: begin
            if (tcnt_q == TW'(TRIG_CYCLES - 1)) state_d = ST_IDLE;
            else                                 tcnt_d  = tcnt_q + TW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         half_q      <= '0;
         tcnt_q      <= '0;
         trig_pend_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         half_q      <= half_d;
         tcnt_q      <= tcnt_d;
         trig_pend_q <= trig_pend_d;
         done_q      <= done_d;
      end
   end

   assign busy   = (state_q != ST_IDLE) || done_q;
   assign done   = done_q;
   assign sck    = (state_q == ST_SHIFT) && !half_q[0];
   assign mosi   = ce_act && shreg_q[FRAME_BITS-1];
   assign spi_ce = !ce_act;
   assign trig   = (state_q == ST_TRIG);

`ifdef SPI_READBACK_EN
   logic [7:0] op_q, op_d, rx_q, rx_d, rd_data_q, rd_data_d;
   logic       rd_valid_q, rd_valid_d;

   // Rising edges of bits 24..31 happen on the ticks that leave odd halves 47..61.
   always_comb begin
      op_d       = op_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (accept) op_d = cmd_op;
      if ((state_q == ST_SHIFT) && tick && half_q[0] && (half_q >= 6'd47) && (half_q <= 6'd61))
         rx_d = {rx_q[6:0], miso};
      if (done_d && (op_q == OP_READ)) begin
         rd_data_d  = rx_q;
         rd_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= '0;
         rx_q       <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         op_q       <= op_d;
         rx_q       <= rx_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`else
   logic unused_miso;

   assign unused_miso = miso;
   assign rd_data     = '0;
   assign rd_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_dds_spi_master.sv
// tb_dds_spi_master: random and directed frames/triggers against a queue-based scoreboard,
// with an SPI slave model that answers reads from a random byte memory.
module tb_dds_spi_master;
   import dds_spi_pkg::*;

   localparam int CLK_DIV     = 4;
   localparam int TRIG_CYCLES = 8;
   localparam int FRAME_LAT   = 67 * CLK_DIV;
`ifdef SPI_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   typedef struct {
      logic [31:0] frame;
      int          acc;
      logic        rv;
      logic [7:0]  rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, trig_req, miso;
   logic [7:0]  cmd_op, cmd_data;
   logic [15:0] cmd_addr;
   logic        cmd_ready, busy, done, rd_valid, sck, mosi, spi_ce, trig;
   logic [7:0]  rd_data;

   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   exp_t        exp_q[$];
   int          trig_q[$];
   logic [7:0]  slave_mem [256];
   logic [7:0]  last_rd;

   dds_spi_master #(.CLK_DIV(CLK_DIV), .TRIG_CYCLES(TRIG_CYCLES)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .trig_req(trig_req),
      .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
      .sck(sck), .mosi(mosi), .miso(miso), .spi_ce(spi_ce), .trig(trig)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Called just after a negedge; returns just after the negedge following the accept edge.
   task automatic applyStimulus(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] data,
                                input bit with_trig, output int acc);
      exp_t e;
      int   n;
      cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      acc = -1;
      if (!cmd_ready) begin
         checkOutput("accept_timeout", 1, 0);
         cmd_valid = 1'b0;
         return;
      end
      trig_req = with_trig;
      acc      = cyc + 1;
      e.frame  = {op, addr, data};
      e.acc    = acc;
      e.rv     = RB && (op == OP_READ);
      if (e.rv) last_rd = slave_mem[addr[7:0]];
      e.rd     = RB ? last_rd : 8'h00;
      exp_q.push_back(e);
      if (with_trig) trig_q.push_back(acc + FRAME_LAT + 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      trig_req  = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0 || trig_q.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) checkOutput("drain_timeout", 1, 0);
      repeat (3) @(negedge clk);
   endtask

   // SPI slave: returns slave_mem[addr[7:0]] during the last 8 bits, changing MISO only while SCK is low.
   initial begin : slave
      int         cnt;
      logic [31:0] rx;
      logic [7:0] ad, byte_v;
      logic       prev;
      cnt = 0; rx = '0; ad = '0; prev = 1'b0; miso = 1'b0;
      forever begin
         @(negedge clk);
         if (spi_ce) begin
            cnt  = 0;
            miso = 1'b0;
         end else begin
            if (sck && !prev) begin
               rx = {rx[30:0], mosi};
               cnt++;
               if (cnt == 24) ad = rx[7:0];
            end
            if (!sck && cnt >= 24 && cnt < 32) begin
               byte_v = slave_mem[ad];
               miso   = byte_v[31 - cnt];
            end
         end
         prev = sck;
      end
   end

   initial begin : monitor
      logic [31:0] word;
      int          rises, ce_cnt, hi_run, tw, ts;
      logic        prev_sck, prev_ce, prev_trig, have_prev;
      exp_t        e;
      word = '0; rises = 0; ce_cnt = 0; hi_run = 0; tw = 0;
      prev_sck = 1'b0; prev_ce = 1'b1; prev_trig = 1'b0; have_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            word = '0; rises = 0; ce_cnt = 0; hi_run = 0; tw = 0;
            prev_sck = 1'b0; prev_ce = 1'b1; prev_trig = 1'b0; have_prev = 1'b0;
         end else begin
            if (sck && !prev_sck) begin
               word = {word[30:0], mosi};
               rises++;
            end
            if (!spi_ce) begin
               if (prev_ce && have_prev) checkOutput("ce_gap_min", (hi_run >= CLK_DIV), 1);
               ce_cnt++;
               hi_run = 0;
            end else begin
               hi_run++;
            end
            if (!done) checkOutput("rd_valid_stray", rd_valid, 0);
            if (done) begin
               if (exp_q.size() == 0) begin
                  checkOutput("done_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("mosi_frame", word, e.frame);
                  checkOutput("sck_rises", rises, 32);
                  checkOutput("done_latency", cyc - e.acc, FRAME_LAT);
                  checkOutput("ce_low_cycles", ce_cnt, 66 * CLK_DIV);
                  checkOutput("rd_valid", rd_valid, e.rv);
                  checkOutput("rd_data", rd_data, e.rd);
                  checkOutput("busy_at_done", busy, 1);
               end
               word = '0; rises = 0; ce_cnt = 0; have_prev = 1'b1;
            end
            if (trig && !prev_trig) begin
               if (trig_q.size() == 0) begin
                  checkOutput("trig_unexpected", 1, 0);
               end else begin
                  ts = trig_q.pop_front();
                  checkOutput("trig_start", cyc, ts);
               end
               tw = 0;
            end
            if (trig) begin
               tw++;
               checkOutput("trig_quiet_spi", {sck, spi_ce, cmd_ready}, 3'b010);
            end
            if (!trig && prev_trig) begin
               checkOutput("trig_width", tw, TRIG_CYCLES);
               checkOutput("ready_after_trig", cmd_ready, 1);
            end
            prev_sck  = sck;
            prev_ce   = spi_ce;
            prev_trig = trig;
         end
      end
   end

   initial begin : stimulus
      int         acc1, acc2, n, r, k;
      logic       ps;
      logic [7:0] op;
      rst = 1'b1; cmd_valid = 1'b0; trig_req = 1'b0;
      cmd_op = '0; cmd_addr = '0; cmd_data = '0; last_rd = 8'h00;
      for (int i = 0; i < 256; i++) slave_mem[i] = 8'($urandom);
      slave_mem[8'h5A] = 8'h3C;

      repeat (3) @(negedge clk);
      checkOutput("rst_cmd_ready", cmd_ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_rd_valid", rd_valid, 0);
      checkOutput("rst_rd_data", rd_data, 0);
      checkOutput("rst_sck", sck, 0);
      checkOutput("rst_mosi", mosi, 0);
      checkOutput("rst_spi_ce", spi_ce, 1);
      checkOutput("rst_trig", trig, 0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] directed write 010123A5");
      applyStimulus(OP_WRITE, 16'h0123, 8'hA5, 1'b0, acc1);
      waitIdle();

      $display("[TB] trigger from idle");
      trig_req = 1'b1;
      trig_q.push_back(cyc + 1);
      @(negedge clk);
      trig_req = 1'b0;
      waitIdle();

      $display("[TB] frame and trigger in the same cycle, next frame held waiting");
      applyStimulus(OP_CTRL, 16'hBEEF, 8'h5A, 1'b1, acc1);
      applyStimulus(OP_WRITE, 16'h4242, 8'h17, 1'b0, acc2);
      checkOutput("accept_after_trig", acc2, acc1 + FRAME_LAT + TRIG_CYCLES + 2);
      waitIdle();

      $display("[TB] back-to-back frames");
      applyStimulus(OP_WRITE, 16'h8001, 8'hFF, 1'b0, acc1);
      applyStimulus(OP_READ, 16'h7F5A, 8'h00, 1'b0, acc2);
      checkOutput("b2b_accept", acc2, acc1 + FRAME_LAT + 1);
      waitIdle();

      $display("[TB] repeated trig_req during a frame");
      applyStimulus(OP_WRITE, 16'h0F0F, 8'h33, 1'b0, acc1);
      trig_q.push_back(acc1 + FRAME_LAT + 1);
      for (int i = 0; i < 3; i++) begin
         repeat (20) @(negedge clk);
         trig_req = 1'b1;
         @(negedge clk);
         trig_req = 1'b0;
      end
      waitIdle();

      $display("[TB] reset during bit 10");
      applyStimulus(OP_WRITE, 16'hAAAA, 8'h55, 1'b0, acc1);
      n = 0; r = 0; ps = 1'b0;
      while (r < 11 && n < 1000) begin
         if (sck && !ps) r++;
         ps = sck;
         if (r < 11) begin
            @(negedge clk);
            n++;
         end
      end
      if (r < 11) checkOutput("rst_wait_timeout", 1, 0);
      rst = 1'b1;
      exp_q.delete();
      trig_q.delete();
      last_rd = 8'h00;
      @(negedge clk);
      checkOutput("midrst_spi_ce", spi_ce, 1);
      checkOutput("midrst_sck", sck, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_cmd_ready", cmd_ready, 1);
      checkOutput("midrst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (FRAME_LAT + 20) @(negedge clk);

      $display("[TB] random frames");
      for (int i = 0; i < 20; i++) begin
         k  = $urandom_range(0, 3);
         op = (k == 0) ? OP_WRITE : (k == 1) ? OP_READ : (k == 2) ? OP_CTRL : 8'($urandom);
         applyStimulus(op, 16'($urandom), 8'($urandom), 1'b0, acc1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      waitIdle();
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
